// File: rtl/fp_addsub_issue_if.sv
// Bundle of the request, add/sub-stage and result signals of fp_addsub_issue.
// The master side is the environment; the slave side is the issue block.
interface fp_addsub_issue_if #(parameter int CNT_W = 16);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic             in_op;
  logic [31:0]      add_a;
  logic [31:0]      add_b;
  logic             add_sign;
  logic [31:0]      add_result;
  logic             add_exception;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic             out_exception;
  logic [CNT_W-1:0] op_count;
  logic [CNT_W-1:0] exc_count;

  modport master (
    output in_valid, in_a, in_b, in_op, add_result, add_exception, out_ready,
    input  in_ready, add_a, add_b, add_sign, out_valid, out_result, out_exception,
           op_count, exc_count
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, add_result, add_exception, out_ready,
    output in_ready, add_a, add_b, add_sign, out_valid, out_result, out_exception,
           op_count, exc_count
  );
endinterface

// File: rtl/fp_addsub_issue.sv
// Issue wrapper around an external combinational FP add/sub stage: one operand
// register feeding the stage, a 2-entry result FIFO, and delivery counters.
module fp_addsub_issue #(
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              rst_n,
  fp_addsub_issue_if.slave bus
);

  logic [1:0]       rst_sync;
  logic             run;

  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic             op_q;
  logic             s1_valid;

  logic [31:0]      fifo_res [2];
  logic             fifo_exc [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       fifo_count;

  logic [CNT_W-1:0] op_cnt;
  logic [CNT_W-1:0] exc_cnt;

  logic             out_valid_c;
  logic             pop;
  logic             push;
  logic             in_ready_c;
  logic             accept;

  // Reset release is delayed two clocks so in_ready never rises on a ragged edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign run         = rst_sync[1];
  assign out_valid_c = (fifo_count != 2'd0);
  assign pop         = out_valid_c & bus.out_ready;
  assign push        = s1_valid & ((fifo_count < 2'd2) | pop);
  assign in_ready_c  = run & (~s1_valid | push);
  assign accept      = bus.in_valid & in_ready_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 1'b0;
      s1_valid <= 1'b0;
    end else begin
      if (accept) begin
        a_q      <= bus.in_a;
        b_q      <= bus.in_b;
        op_q     <= bus.in_op;
        s1_valid <= 1'b1;
      end else if (push) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Storage needs no reset: an entry is only visible once fifo_count covers it.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_res[wr_ptr] <= bus.add_result;
      fifo_exc[wr_ptr] <= bus.add_exception;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt  <= '0;
      exc_cnt <= '0;
    end else if (pop) begin
      op_cnt <= op_cnt + 1'b1;
      if (fifo_exc[rd_ptr] && (exc_cnt != '1)) exc_cnt <= exc_cnt + 1'b1;
    end
  end

  assign bus.in_ready      = in_ready_c;
  assign bus.add_a         = a_q;
  assign bus.add_b         = b_q;
  assign bus.add_sign      = op_q;
  assign bus.out_valid     = out_valid_c;
  assign bus.out_result    = fifo_res[rd_ptr];
  assign bus.out_exception = fifo_exc[rd_ptr];
  assign bus.op_count      = op_cnt;
  assign bus.exc_count     = exc_cnt;

  a_no_push_when_full : assert property (
    @(posedge clk) disable iff (!rst_n) !(push && !pop && (fifo_count == 2'd2))
  );

endmodule

// File: tb/tb_fp_addsub_issue.sv
// Randomised scoreboard bench for fp_addsub_issue, including a real-arithmetic
// model of the downstream add/sub stage.
module tb_fp_addsub_issue;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rand_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int ops_issued = 0;

  logic [32:0]      exp_q [$];
  logic [CNT_W-1:0] exp_op = '0;
  logic [CNT_W-1:0] exp_exc = '0;

  fp_addsub_issue_if #(.CNT_W(CNT_W)) bus ();

  fp_addsub_issue #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic real f2r(logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) return 0.0;
    d = {f[31], 11'({3'b000, f[30:23]} + 11'd896), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  // Round-to-nearest-even from double to single; operands stay in the normal range.
  function automatic logic [31:0] r2f(real r);
    logic [63:0] d;
    logic [10:0] e;
    logic [22:0] keep;
    logic        g;
    logic        s;
    logic [30:0] mag;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e    = d[62:52];
    keep = d[51:29];
    g    = d[28];
    s    = |d[27:0];
    mag  = {8'(e - 11'd896), keep};
    if (g && (s || keep[0])) mag = mag + 31'd1;
    return {d[63], mag};
  endfunction

  function automatic logic [32:0] ref_add(logic [31:0] a, logic [31:0] b, logic sub);
    real ra;
    real rb;
    if ((a[30:23] == 8'hFF) || (b[30:23] == 8'hFF)) return {1'b1, 32'hFFFF_FFFF};
    ra = f2r(a);
    rb = f2r(b);
    return {1'b0, r2f(sub ? (ra - rb) : (ra + rb))};
  endfunction

  function automatic logic [31:0] rand_fp();
    return {1'($urandom), 8'($urandom_range(150, 100)), 23'($urandom)};
  endfunction

  always_comb {bus.add_exception, bus.add_result} = ref_add(bus.add_a, bus.add_b, bus.add_sign);

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  // Every accepted request records its expected response at issue time.
  always begin
    @(negedge clk);
    #1;
    if (rst_n && bus.in_valid && bus.in_ready)
      exp_q.push_back(ref_add(bus.in_a, bus.in_b, bus.in_op));
  end

  always @(negedge clk) begin
    if (rst_n) begin
      logic [32:0] e;
      check_output("op_count", 32'(bus.op_count), 32'(exp_op));
      check_output("exc_count", 32'(bus.exc_count), 32'(exp_exc));
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL stale_out_valid got result %h want no output at %0t", bus.out_result, $time);
        end else if (bus.out_ready) begin
          e = exp_q.pop_front();
          check_output("out_result", bus.out_result, e[31:0]);
          check_output("out_exception", 32'(bus.out_exception), 32'(e[32]));
          exp_op = exp_op + 1'b1;
          if (e[32] && (exp_exc != '1)) exp_exc = exp_exc + 1'b1;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      if (rand_ready) bus.out_ready = ($urandom_range(3, 0) != 0);
    end
  end

  task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b, input logic op,
                                output int waited);
    bit done;
    done = 1'b0;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_op = op;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) done = 1'b1;
      else waited++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout got in_ready 0 want 1 at %0t", $time);
    end else begin
      ops_issued++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.out_valid) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout got %0d pending want 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    #12;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_output("in_ready_edge1", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    check_output("in_ready_edge2", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int w;
    int stalls;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_op = 1'b0;
    bus.out_ready = 1'b1;

    #1;
    rst_n = 1'b0;
    #1;
    check_output("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check_output("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("rst_add_a", bus.add_a, 32'd0);
    check_output("rst_add_b", bus.add_b, 32'd0);
    check_output("rst_add_sign", 32'(bus.add_sign), 32'd0);
    check_output("rst_op_count", 32'(bus.op_count), 32'd0);
    check_output("rst_exc_count", 32'(bus.exc_count), 32'd0);
    repeat (3) @(posedge clk);
    release_reset();

    // Single 1.0 + 2.0.
    apply_stimulus(32'h3F80_0000, 32'h4000_0000, 1'b0, w);
    check_output("s1_add_a", bus.add_a, 32'h3F80_0000);
    check_output("s1_add_b", bus.add_b, 32'h4000_0000);
    check_output("s1_add_sign", 32'(bus.add_sign), 32'd0);
    @(posedge clk);
    #1;
    check_output("single_out_valid", 32'(bus.out_valid), 32'd1);
    check_output("single_out_result", bus.out_result, 32'h4040_0000);
    @(posedge clk);
    #1;
    check_output("single_op_count", 32'(bus.op_count), 32'd1);
    check_output("single_out_valid_gone", 32'(bus.out_valid), 32'd0);

    // Infinite operand raises the exception path.
    apply_stimulus(32'h7F80_0000, 32'h3F80_0000, 1'b0, w);
    @(posedge clk);
    #1;
    check_output("exc_flag", 32'(bus.out_exception), 32'd1);
    check_output("exc_result", bus.out_result, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    check_output("exc_count_one", 32'(bus.exc_count), 32'd1);

    // Back-pressure: three requests fit, the fourth waits for out_ready.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(rand_fp(), rand_fp(), 1'($urandom), w);
      check_output("bp_accept_wait", 32'(w), 32'd0);
    end
    bus.in_valid = 1'b1;
    bus.in_a = rand_fp();
    bus.in_b = rand_fp();
    bus.in_op = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_output("bp_in_ready_release", 32'(bus.in_ready), 32'd1);
    if (bus.in_ready) ops_issued++;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_drain();

    // Streaming at full rate; the FIFO settles at one entry.
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      apply_stimulus(rand_fp(), rand_fp(), 1'($urandom), w);
      if (i > 0) stalls += w;
      if (i >= 10 && i < 20) check_output("steady_fifo_count", 32'(dut.fifo_count), 32'd1);
    end
    check_output("stream_stalls", 32'(stalls), 32'd0);
    wait_drain();

    // Exception-heavy stream with random back-pressure: exc_count saturates, op_count wraps.
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(7, 0) != 0) apply_stimulus(32'h7F80_0000, rand_fp(), 1'($urandom), w);
      else apply_stimulus(rand_fp(), rand_fp(), 1'($urandom), w);
    end
    rand_ready = 1'b0;
    bus.out_ready = 1'b1;
    wait_drain();
    check_output("exc_saturated", 32'(bus.exc_count), 32'h0000_00FF);
    check_output("op_count_wrap", 32'(bus.op_count), 32'(ops_issued % 256));

    // Reset with S1 and FIFO full.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) apply_stimulus(rand_fp(), rand_fp(), 1'($urandom), w);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    exp_op = '0;
    exp_exc = '0;
    #1;
    check_output("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("midrst_op_count", 32'(bus.op_count), 32'd0);
    check_output("midrst_exc_count", 32'(bus.exc_count), 32'd0);
    check_output("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    check_output("midrst_add_a", bus.add_a, 32'd0);
    bus.out_ready = 1'b1;
    release_reset();
    check_output("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    apply_stimulus(32'h4120_0000, 32'h3F80_0000, 1'b1, w);
    @(posedge clk);
    #1;
    check_output("post_rst_first_result", bus.out_result, 32'h4110_0000);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
